// File: rtl/regfile_scheduler.sv
// regfile_scheduler
//
// Sequences a single-port 32x32 register file SRAM and shares it between an
// operand-read requester (two source registers per request) and a write-back
// requester (one destination register per request). Every SRAM control output
// is a flop, so the register file always sees glitch-free, whole-cycle-stable
// REG_SEL / REG_SRCx / IN_DATA / N_WE / N_OE.
//
// Ports
//   CLK, RST          clock; synchronous active-high reset
//   RD_REQ/RD_READY   operand read handshake, indices on RD_SRC0/RD_SRC1
//   RD_DONE           one-cycle pulse, OP0/OP1 valid (held until next pulse)
//   WR_REQ/WR_READY   write-back handshake, WR_DST/WR_DATA
//   WR_DONE           one-cycle pulse, write committed
//   REG_SEL           register file source select (00 src0, 01 src1, 10 src2)
//   REG_SRC0/1/2      latched read indices and write index
//   N_WE, N_OE        active-low write / output enables
//   IN_DATA           latched write data
//   OUT_DATA          combinational read data from the register file
module regfile_scheduler #(
  parameter int WIDTH        = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RD_REQ,
  input  logic [4:0]       RD_SRC0,
  input  logic [4:0]       RD_SRC1,
  output logic             RD_READY,
  output logic             RD_DONE,
  output logic [WIDTH-1:0] OP0,
  output logic [WIDTH-1:0] OP1,
  input  logic             WR_REQ,
  input  logic [4:0]       WR_DST,
  input  logic [WIDTH-1:0] WR_DATA,
  output logic             WR_READY,
  output logic             WR_DONE,
  output logic [1:0]       REG_SEL,
  output logic [4:0]       REG_SRC0,
  output logic [4:0]       REG_SRC1,
  output logic [4:0]       REG_SRC2,
  output logic             N_WE,
  output logic             N_OE,
  output logic [WIDTH-1:0] IN_DATA,
  input  logic [WIDTH-1:0] OUT_DATA
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ0 = 2'd1,
    READ1 = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [3:0]       starve_cnt;
  logic [3:0]       starve_next;
  logic [1:0]       reg_sel_next;
  logic             n_we_next;
  logic             n_oe_next;
  logic [WIDTH-1:0] op0_buf;
  logic             idle;
  logic             starved;
  logic             rd_grant;
  logic             wr_grant;

  // Arbitration: write normally wins a tie so results retire quickly, but once
  // the starve counter reaches its limit the pending read is forced through.
  // Only the winner sees READY, so the loser simply stays pending.
  assign idle     = (state == IDLE);
  assign starved  = (starve_cnt == LIMIT);
  assign RD_READY = idle && !RST && (!WR_REQ || starved);
  assign WR_READY = idle && !RST && !(RD_REQ && starved);
  assign rd_grant = RD_REQ && RD_READY;
  assign wr_grant = WR_REQ && WR_READY;

  // Next-state, starve-counter and next SRAM-control decode. The SRAM
  // controls are derived from the state being entered so that the flops below
  // present them for exactly the cycle that state occupies.
  always_comb begin
    next_state   = state;
    starve_next  = starve_cnt;
    reg_sel_next = 2'b00;
    n_we_next    = 1'b1;
    n_oe_next    = 1'b1;

    unique case (state)
      IDLE: begin
        if (rd_grant) begin
          next_state = READ0;
        end else if (wr_grant) begin
          next_state = WRITE;
        end

        if (rd_grant || !RD_REQ) begin
          starve_next = 4'd0;
        end else if (wr_grant && (starve_cnt < LIMIT)) begin
          starve_next = starve_cnt + 4'd1;
        end
      end
      READ0:   next_state = READ1;
      READ1:   next_state = IDLE;
      WRITE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase

    unique case (next_state)
      READ0: begin
        reg_sel_next = 2'b00;
        n_oe_next    = 1'b0;
      end
      READ1: begin
        reg_sel_next = 2'b01;
        n_oe_next    = 1'b0;
      end
      WRITE: begin
        reg_sel_next = 2'b10;
        // Register 0 is hard-wired zero: the cycle is still spent but the
        // SRAM is never actually written.
        n_we_next    = (WR_DST == 5'd0);
      end
      default: begin
        reg_sel_next = 2'b00;
      end
    endcase
  end

  // State, registered SRAM controls, latched request fields and operands.
  // OP0 is staged in op0_buf during READ0 so both operands change together
  // on the RD_DONE pulse and stay put until the next one.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      REG_SEL    <= 2'b00;
      N_WE       <= 1'b1;
      N_OE       <= 1'b1;
      REG_SRC0   <= 5'd0;
      REG_SRC1   <= 5'd0;
      REG_SRC2   <= 5'd0;
      IN_DATA    <= '0;
      op0_buf    <= '0;
      OP0        <= '0;
      OP1        <= '0;
      RD_DONE    <= 1'b0;
      WR_DONE    <= 1'b0;
    end else begin
      state      <= next_state;
      starve_cnt <= starve_next;
      REG_SEL    <= reg_sel_next;
      N_WE       <= n_we_next;
      N_OE       <= n_oe_next;
      RD_DONE    <= (state == READ1);
      WR_DONE    <= (state == WRITE);

      if (rd_grant) begin
        REG_SRC0 <= RD_SRC0;
        REG_SRC1 <= RD_SRC1;
      end
      if (wr_grant) begin
        REG_SRC2 <= WR_DST;
        IN_DATA  <= WR_DATA;
      end

      if (state == READ0) begin
        op0_buf <= (REG_SRC0 == 5'd0) ? '0 : OUT_DATA;
      end
      if (state == READ1) begin
        OP0 <= op0_buf;
        OP1 <= (REG_SRC1 == 5'd0) ? '0 : OUT_DATA;
      end
    end
  end

endmodule

// File: tb/tb_regfile_scheduler.sv
// tb_regfile_scheduler
//
// Bench for regfile_scheduler. Holds a behavioural register file (the SRAM
// the scheduler drives) and a transaction-level reference model that predicts
// READY, DONE, operand values and the SRAM control pattern from the
// handshakes it observes. Directed scenarios add hand-computed expectations.
module tb_regfile_scheduler;

  localparam int WIDTH = 32;
  localparam int LIMIT = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             RD_REQ = 1'b0;
  logic [4:0]       RD_SRC0 = 5'd0;
  logic [4:0]       RD_SRC1 = 5'd0;
  logic             WR_REQ = 1'b0;
  logic [4:0]       WR_DST = 5'd0;
  logic [WIDTH-1:0] WR_DATA = '0;
  logic             RD_READY;
  logic             RD_DONE;
  logic [WIDTH-1:0] OP0;
  logic [WIDTH-1:0] OP1;
  logic             WR_READY;
  logic             WR_DONE;
  logic [1:0]       REG_SEL;
  logic [4:0]       REG_SRC0;
  logic [4:0]       REG_SRC1;
  logic [4:0]       REG_SRC2;
  logic             N_WE;
  logic             N_OE;
  logic [WIDTH-1:0] IN_DATA;
  logic [WIDTH-1:0] OUT_DATA;

  regfile_scheduler #(.WIDTH(WIDTH), .STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .RST(RST),
    .RD_REQ(RD_REQ), .RD_SRC0(RD_SRC0), .RD_SRC1(RD_SRC1),
    .RD_READY(RD_READY), .RD_DONE(RD_DONE), .OP0(OP0), .OP1(OP1),
    .WR_REQ(WR_REQ), .WR_DST(WR_DST), .WR_DATA(WR_DATA),
    .WR_READY(WR_READY), .WR_DONE(WR_DONE),
    .REG_SEL(REG_SEL), .REG_SRC0(REG_SRC0), .REG_SRC1(REG_SRC1),
    .REG_SRC2(REG_SRC2), .N_WE(N_WE), .N_OE(N_OE),
    .IN_DATA(IN_DATA), .OUT_DATA(OUT_DATA)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int last_rd_hs = -100;
  int last_wr_hs = -100;
  int we_low_count = 0;

  // Cycle counter, stable when sampled on the falling edge.
  always @(posedge CLK) cyc <= cyc + 1;

  // Count cycles in which the register file actually sees a write strobe.
  always @(posedge CLK) if (!N_WE) we_low_count <= we_low_count + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Register file model: power-up contents are a known non-zero pattern
  // (register 0 included, so forced-zero reads are visible). It shares the
  // synchronous reset, so a write strobe in a reset cycle is dropped.
  logic [31:0] mem [32];
  bit   [31:0] wrote;
  logic [4:0]  rd_idx;

  function automatic logic [31:0] initVal(input int i);
    return 32'hC0DE0000 | 32'(i);
  endfunction

  always @(posedge CLK) begin
    if (!N_WE && !RST) begin
      mem[REG_SRC2]   <= IN_DATA;
      wrote[REG_SRC2] <= 1'b1;
    end
  end

  assign rd_idx   = (REG_SEL == 2'b01) ? REG_SRC1 : REG_SRC0;
  assign OUT_DATA = N_OE ? 32'hBAD0BAD0 : (wrote[rd_idx] ? mem[rd_idx] : initVal(int'(rd_idx)));

  // Reference model: a 32-entry architectural register array plus the
  // cycle each outstanding transaction was accepted. Read handshake in cycle
  // n -> READ0 in n+1, READ1 in n+2, RD_DONE in n+3; write handshake in n ->
  // WRITE in n+1, WR_DONE in n+2; writes commit at the end of the WRITE cycle.
  logic [31:0] ref_mem [32];
  bit          known = 1'b0;
  int          rd_hs_c = -100;
  int          wr_hs_c = -100;
  logic [4:0]  m_src0, m_src1, m_dst;
  logic [31:0] m_data, pend0, pend1, exp_op0, exp_op1;
  int          starve = 0;

  always @(negedge CLK) begin
    bit rd_hs, wr_hs, idle, exp_rd_rdy, exp_wr_rdy;
    rd_hs = RD_REQ && RD_READY;
    wr_hs = WR_REQ && WR_READY;
    idle  = !((cyc == rd_hs_c + 1) || (cyc == rd_hs_c + 2) || (cyc == wr_hs_c + 1));

    if (known) begin
      exp_rd_rdy = idle && !RST && !(WR_REQ && (starve != LIMIT));
      exp_wr_rdy = idle && !RST && !(RD_REQ && (starve == LIMIT));
      checkOutput("rd_ready", RD_READY, exp_rd_rdy);
      checkOutput("wr_ready", WR_READY, exp_wr_rdy);
      checkOutput("we_oe_not_both_low", N_WE | N_OE, 1);
      checkOutput("reg_sel_legal", REG_SEL == 2'b11, 0);

      if (cyc == rd_hs_c + 1) begin
        checkOutput("read0_sel", REG_SEL, 0);
        checkOutput("read0_oe", N_OE, 0);
        checkOutput("read0_we", N_WE, 1);
        checkOutput("read0_src0", REG_SRC0, m_src0);
        checkOutput("read0_src1", REG_SRC1, m_src1);
      end else if (cyc == rd_hs_c + 2) begin
        checkOutput("read1_sel", REG_SEL, 1);
        checkOutput("read1_oe", N_OE, 0);
        checkOutput("read1_we", N_WE, 1);
      end else if (cyc == wr_hs_c + 1) begin
        checkOutput("write_sel", REG_SEL, 2);
        checkOutput("write_oe", N_OE, 1);
        checkOutput("write_we", N_WE, m_dst == 5'd0);
        checkOutput("write_dst", REG_SRC2, m_dst);
        checkOutput("write_data", IN_DATA, m_data);
      end else begin
        checkOutput("idle_sel", REG_SEL, 0);
        checkOutput("idle_oe", N_OE, 1);
        checkOutput("idle_we", N_WE, 1);
      end

      checkOutput("rd_done", RD_DONE, cyc == rd_hs_c + 3);
      checkOutput("wr_done", WR_DONE, cyc == wr_hs_c + 2);
      if (cyc == rd_hs_c + 3) begin
        exp_op0 = pend0;
        exp_op1 = pend1;
      end
      checkOutput("op0", OP0, exp_op0);
      checkOutput("op1", OP1, exp_op1);
    end

    if (RST) begin
      if (!known) begin
        for (int i = 0; i < 32; i++) ref_mem[i] = initVal(i);
      end
      known   = 1'b1;
      rd_hs_c = -100;
      wr_hs_c = -100;
      starve  = 0;
      exp_op0 = '0;
      exp_op1 = '0;
    end else if (known) begin
      if ((cyc == wr_hs_c + 1) && (m_dst != 5'd0)) ref_mem[m_dst] = m_data;
      if (idle) begin
        if (rd_hs || !RD_REQ) starve = 0;
        else if (wr_hs && starve < LIMIT) starve = starve + 1;
      end
      if (rd_hs) begin
        rd_hs_c = cyc;
        m_src0  = RD_SRC0;
        m_src1  = RD_SRC1;
        pend0   = (RD_SRC0 == 5'd0) ? 32'd0 : ref_mem[RD_SRC0];
        pend1   = (RD_SRC1 == 5'd0) ? 32'd0 : ref_mem[RD_SRC1];
      end
      if (wr_hs) begin
        wr_hs_c = cyc;
        m_dst   = WR_DST;
        m_data  = WR_DATA;
      end
    end
  end

  // Raise the requested transactions and hold each until its handshake.
  // Returns one cycle after the last handshake, #1 past the rising edge.
  task automatic applyStimulus(input bit rd, input logic [4:0] s0, input logic [4:0] s1,
                               input bit wr, input logic [4:0] dst, input logic [31:0] data);
    bit rd_left, wr_left;
    int n;
    @(posedge CLK); #1;
    RD_REQ  = rd;  RD_SRC0 = s0;  RD_SRC1 = s1;
    WR_REQ  = wr;  WR_DST  = dst; WR_DATA = data;
    rd_left = rd;  wr_left = wr;  n = 0;
    while ((rd_left || wr_left) && n < 50) begin
      @(negedge CLK);
      if (rd_left && RD_READY) begin rd_left = 1'b0; last_rd_hs = cyc; end
      if (wr_left && WR_READY) begin wr_left = 1'b0; last_wr_hs = cyc; end
      @(posedge CLK); #1;
      if (!rd_left) RD_REQ = 1'b0;
      if (!wr_left) WR_REQ = 1'b0;
      n++;
    end
    checkOutput("handshake_within_bound", rd_left | wr_left, 0);
    RD_REQ = 1'b0;
    WR_REQ = 1'b0;
  endtask

  task automatic waitDone(input bit want_rd, output int c);
    c = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge CLK);
      if (want_rd ? RD_DONE : WR_DONE) begin
        c = cyc;
        break;
      end
    end
  endtask

  initial begin
    int c, we_before, n;
    byte g[$];
    bit hr, hw;

    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    // Reset values
    @(negedge CLK);
    checkOutput("rst_op0", OP0, 0);
    checkOutput("rst_op1", OP1, 0);
    checkOutput("rst_we", N_WE, 1);
    checkOutput("rst_oe", N_OE, 1);
    checkOutput("rst_sel", REG_SEL, 0);
    checkOutput("rst_src2", REG_SRC2, 0);
    checkOutput("rst_in_data", IN_DATA, 0);
    checkOutput("rst_dones", {RD_DONE, WR_DONE}, 0);
    checkOutput("rst_readys", {RD_READY, WR_READY}, 2'b11);

    $display("[TB] write r5 then read (r5,r0)");
    applyStimulus(0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
    waitDone(0, c);
    checkOutput("t1_wr_latency", 32'(c - last_wr_hs), 2);
    applyStimulus(1, 5'd5, 5'd0, 0, 0, 0);
    waitDone(1, c);
    checkOutput("t1_rd_latency", 32'(c - last_rd_hs), 3);
    checkOutput("t1_op0", OP0, 32'hDEADBEEF);
    checkOutput("t1_op1", OP1, 32'h0);

    $display("[TB] write r0 then read (r0,r0)");
    we_before = we_low_count;
    applyStimulus(0, 0, 0, 1, 5'd0, 32'h12345678);
    waitDone(0, c);
    checkOutput("t2_wr_done_latency", 32'(c - last_wr_hs), 2);
    checkOutput("t2_no_we_strobe", 32'(we_low_count - we_before), 0);
    applyStimulus(1, 5'd0, 5'd0, 0, 0, 0);
    waitDone(1, c);
    checkOutput("t2_op0", OP0, 32'h0);
    checkOutput("t2_op1", OP1, 32'h0);

    $display("[TB] simultaneous read r7,r7 and write r7");
    applyStimulus(1, 5'd7, 5'd7, 1, 5'd7, 32'hA5A5A5A5);
    checkOutput("t3_write_first", 32'(last_rd_hs - last_wr_hs), 2);
    waitDone(1, c);
    checkOutput("t3_op0", OP0, 32'hA5A5A5A5);
    checkOutput("t3_op1", OP1, 32'hA5A5A5A5);

    $display("[TB] continuous read and write pressure");
    @(posedge CLK); #1;
    RD_REQ = 1'b1; RD_SRC0 = 5'd10; RD_SRC1 = 5'd11;
    WR_REQ = 1'b1; WR_DST = 5'd10; WR_DATA = 32'h40000000;
    n = 0;
    while (g.size() < 10 && n < 200) begin
      @(negedge CLK);
      hr = RD_READY;
      hw = WR_READY;
      if (hr) g.push_back("R");
      if (hw) g.push_back("W");
      @(posedge CLK); #1;
      if (hw) begin
        WR_DST  = (WR_DST == 5'd10) ? 5'd11 : 5'd10;
        WR_DATA = WR_DATA + 32'd1;
      end
      n++;
    end
    RD_REQ = 1'b0;
    WR_REQ = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("t4_grant%0d", i), (g.size() > i) ? 32'(g[i]) : 32'd0,
                  (i % 5 == 4) ? 32'("R") : 32'("W"));
    end
    repeat (4) @(posedge CLK);

    $display("[TB] reset during WRITE");
    applyStimulus(0, 0, 0, 1, 5'd9, 32'h11111111);
    waitDone(0, c);
    applyStimulus(0, 0, 0, 1, 5'd9, 32'h22222222);
    checkOutput("t5w_in_write", N_WE, 0);
    RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK);
    checkOutput("t5w_we", N_WE, 1);
    checkOutput("t5w_oe", N_OE, 1);
    checkOutput("t5w_sel", REG_SEL, 0);
    checkOutput("t5w_readys", {RD_READY, WR_READY}, 2'b11);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t5w_no_done", WR_DONE, 0);
      @(negedge CLK);
    end
    applyStimulus(1, 5'd9, 5'd9, 0, 0, 0);
    waitDone(1, c);
    checkOutput("t5w_r9_unchanged", OP0, 32'h11111111);

    $display("[TB] reset during READ1");
    applyStimulus(1, 5'd9, 5'd5, 0, 0, 0);
    @(posedge CLK); #1;
    checkOutput("t5r_in_read1", {N_OE, REG_SEL}, 3'b001);
    RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK);
    checkOutput("t5r_we", N_WE, 1);
    checkOutput("t5r_oe", N_OE, 1);
    checkOutput("t5r_sel", REG_SEL, 0);
    checkOutput("t5r_readys", {RD_READY, WR_READY}, 2'b11);
    checkOutput("t5r_op0_cleared", OP0, 0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t5r_no_done", RD_DONE, 0);
      @(negedge CLK);
    end

    $display("[TB] mixed traffic");
    for (int i = 0; i < 30; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      applyStimulus(kind != 1, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    kind != 0, 5'($urandom_range(0, 7)), $urandom);
    end
    repeat (6) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
